mem_port_arbiter: RTL
=====================

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 Parameter ADDR_W, default 11, memory address width.
REQ-002 Parameter DATA_W, default 32, memory data width.
REQ-003 Parameter TIMEOUT, default 15, max WAIT cycles before error abort.
REQ-004 clk  in  1  single clock; all state on rising edge.
REQ-005 rst  in  1  reset, asynchronous, active-high.
REQ-006 reqN_rd, reqN_wr (N=0,1)  in  1 each  core N load / store request, level, held until ackN.
REQ-007 reqN_adrs  in  ADDR_W  core N address.
REQ-008 reqN_wdata  in  DATA_W  core N store data.
REQ-009 ackN  out  1  one-cycle completion pulse to core N.
REQ-010 errN  out  1  qualifies ackN; 1 = transaction timed out.
REQ-011 rdataN  out  DATA_W  load data to core N, valid with ackN on loads.
REQ-012 mem_r_en, mem_w_en  out  1 each  one-cycle memory read / write strobe.
REQ-013 mem_adrs  out  ADDR_W  memory address.
REQ-014 mem_wdata  out  DATA_W  memory write data.
REQ-015 mem_r_valid, mem_w_valid  in  1 each  memory completion.
REQ-016 mem_rdata  in  DATA_W  memory read data.
REQ-017 busy  out  1  high in any state except IDLE.

Function
REQ-018 FSM states IDLE, ISSUE, WAIT, DONE; exactly one transaction in flight.
REQ-019 IDLE: if any reqN_rd|reqN_wr, latch owner, op, address, wdata into registers; go ISSUE; else stay.
REQ-020 Owner selection: one requester -> it; both -> core indicated by round-robin pointer rr.
REQ-021 Same core with rd and wr both high -> treated as write.
REQ-022 ISSUE: assert mem_w_en (write) or mem_r_en (read) for exactly one cycle, with mem_adrs/mem_wdata from latched registers; go WAIT; clear timeout counter.
REQ-023 mem_adrs/mem_wdata hold latched values from ISSUE through DONE; 0 in IDLE.
REQ-024 WAIT: matching valid (mem_r_valid for read, mem_w_valid for write) -> capture mem_rdata (reads), go DONE, err flag 0; non-matching valid ignored.
REQ-025 WAIT: counter increments each cycle without matching valid; on reaching TIMEOUT -> go DONE, err flag 1, rdata captured as 0.
REQ-026 Matching valid in the same cycle the counter reaches TIMEOUT -> success wins.
REQ-027 DONE: assert ackOwner (and errOwner if flagged) for one cycle; rdataOwner holds captured data until next ack to that core; rr set to the other core; go IDLE.
REQ-028 Best-case latency: request seen in IDLE cycle T -> strobe T+1 -> valid at T+2 -> ack T+3.
REQ-029 Requester may drop request in the ack cycle; request still high in IDLE after ack is a new transaction.
REQ-030 Requests arriving outside IDLE wait; a request withdrawn before capture is lost without error.
REQ-031 ackN never asserted for the non-owning core; ack0 and ack1 never both high.

Reset
REQ-032 rst asserted: state IDLE, rr=0 (core 0 first), counter 0, all outputs 0, rdataN 0, latched registers 0.
REQ-033 rst mid-transaction aborts it with no ack; late mem valids after reset release are ignored in IDLE.

Verification
REQ-034 Single load: req0_rd=1, adrs=0x012, mem_r_valid + mem_rdata=0xDEADBEEF one cycle after mem_r_en -> mem_r_en pulse at T+1 adrs 0x012, ack0 at T+3, rdata0=0xDEADBEEF, err0=0.
REQ-035 Contention: req0_wr and req1_rd both high from reset, held -> core 0 served first, then core 1, then core 0; never two strobes without intervening ack.
REQ-036 Store: req1_wr adrs=0x7FF wdata=0x0000_00A5, mem_w_valid after 3 cycles -> mem_w_en once with 0x7FF/0xA5, ack1 after valid, err1=0.
REQ-037 Timeout: req0_rd, memory never responds -> ack0=1, err0=1, rdata0=0 exactly TIMEOUT WAIT cycles after strobe; busy drops next cycle.
REQ-038 Reset mid-WAIT: assert rst while WAIT, release, then pulse mem_r_valid -> no ack, busy=0, rr=0.
REQ-039 Boundary: matching valid in cycle counter hits TIMEOUT -> err=0; mem_w_valid during read WAIT ignored.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one memory port between two cores.
// One transaction in flight, round-robin on contention, timeout abort.
module mem_port_arbiter #(
  parameter int ADDR_W  = 11,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0_rd,
  input  logic              req0_wr,
  input  logic [ADDR_W-1:0] req0_adrs,
  input  logic [DATA_W-1:0] req0_wdata,
  input  logic              req1_rd,
  input  logic              req1_wr,
  input  logic [ADDR_W-1:0] req1_adrs,
  input  logic [DATA_W-1:0] req1_wdata,
  output logic              ack0,
  output logic              err0,
  output logic [DATA_W-1:0] rdata0,
  output logic              ack1,
  output logic              err1,
  output logic [DATA_W-1:0] rdata1,
  output logic              mem_r_en,
  output logic              mem_w_en,
  output logic [ADDR_W-1:0] mem_adrs,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_r_valid,
  input  logic              mem_w_valid,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    DONE
  } state_t;

  state_t            state;
  logic              rr;
  logic              owner;
  logic              op_wr;
  logic [ADDR_W-1:0] adrs_q;
  logic [DATA_W-1:0] wdata_q;
  logic [CNT_W-1:0]  cnt;

  logic              want0;
  logic              want1;
  logic              pick1;
  logic              pick_wr;
  logic [ADDR_W-1:0] pick_adrs;
  logic [DATA_W-1:0] pick_wdata;
  logic              match;
  logic [CNT_W-1:0]  cnt_inc;
  logic              expired;
  logic [DATA_W-1:0] cap;

  assign want0 = req0_rd | req0_wr;
  assign want1 = req1_rd | req1_wr;
  // core 1 wins only when alone or when it holds the turn
  assign pick1      = want1 & (~want0 | rr);
  assign pick_wr    = pick1 ? req1_wr    : req0_wr;
  assign pick_adrs  = pick1 ? req1_adrs  : req0_adrs;
  assign pick_wdata = pick1 ? req1_wdata : req0_wdata;

  assign match   = op_wr ? mem_w_valid : mem_r_valid;
  assign cnt_inc = cnt + CNT_W'(1);
  assign expired = (cnt_inc == CNT_MAX);
  assign cap     = match ? mem_rdata : '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      rr        <= 1'b0;
      owner     <= 1'b0;
      op_wr     <= 1'b0;
      adrs_q    <= '0;
      wdata_q   <= '0;
      cnt       <= '0;
      ack0      <= 1'b0;
      err0      <= 1'b0;
      rdata0    <= '0;
      ack1      <= 1'b0;
      err1      <= 1'b0;
      rdata1    <= '0;
      mem_r_en  <= 1'b0;
      mem_w_en  <= 1'b0;
      mem_adrs  <= '0;
      mem_wdata <= '0;
      busy      <= 1'b0;
    end else begin
      ack0     <= 1'b0;
      ack1     <= 1'b0;
      err0     <= 1'b0;
      err1     <= 1'b0;
      mem_r_en <= 1'b0;
      mem_w_en <= 1'b0;
      unique case (state)
        IDLE: begin
          if (want0 | want1) begin
            owner     <= pick1;
            op_wr     <= pick_wr;
            adrs_q    <= pick_adrs;
            wdata_q   <= pick_wdata;
            // strobe is registered so it is high for the ISSUE cycle
            mem_w_en  <= pick_wr;
            mem_r_en  <= ~pick_wr;
            mem_adrs  <= pick_adrs;
            mem_wdata <= pick_wdata;
            busy      <= 1'b1;
            state     <= ISSUE;
          end
        end
        ISSUE: begin
          cnt   <= '0;
          state <= WAIT;
        end
        WAIT: begin
          if (match || expired) begin
            state <= DONE;
            if (owner) begin
              ack1 <= 1'b1;
              err1 <= ~match;
              if (!op_wr) rdata1 <= cap;
            end else begin
              ack0 <= 1'b1;
              err0 <= ~match;
              if (!op_wr) rdata0 <= cap;
            end
          end else begin
            cnt <= cnt_inc;
          end
        end
        DONE: begin
          rr        <= ~owner;
          mem_adrs  <= '0;
          mem_wdata <= '0;
          busy      <= 1'b0;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
